game_ctrl: RTL and testbench

- Top-level game sequencer between the button/frame-timing logic and the game physics and display blocks.
- Runs the game state machine (IDLE, READY, PLAY, DIE, OVER) and gates physics and scrolling.
- Issues one-cycle flap and game-reset strobes.
- Keeps the current and best score in 4-digit BCD for the score display layer.
- All decisions are aligned to frame boundaries (new_frame) or to button pulses.

---
 rtl/game_ctrl_pkg.sv | 36 +++
 rtl/bcd_counter4.sv | 50 +++++
 rtl/game_ctrl.sv | 165 ++++++++++++++++
 tb/tb_game_ctrl.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/game_ctrl_pkg.sv
// Shared encodings for the game sequencer, bird sprite selector and score display.
// Also holds the BCD helpers used by the score counter.
package game_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READY = 3'd1,
        ST_PLAY  = 3'd2,
        ST_DIE   = 3'd3,
        ST_OVER  = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        BIRD_HOVER = 2'd0,
        BIRD_FLY   = 2'd1,
        BIRD_DEAD  = 2'd2
    } bird_e;

    localparam logic [15:0] BCD_MAX = 16'h9999;

    // Most significant differing digit decides; equal scores are not "greater".
    function automatic logic bcd_gt(input logic [15:0] a, input logic [15:0] b);
        logic gt;
        logic decided;
        gt      = 1'b0;
        decided = 1'b0;
        for (int i = 3; i >= 0; i--) begin
            if (!decided && (a[4*i +: 4] != b[4*i +: 4])) begin
                gt      = (a[4*i +: 4] > b[4*i +: 4]);
                decided = 1'b1;
            end
        end
        return gt;
    endfunction

endpackage

// File: rtl/bcd_counter4.sv
// Four-digit BCD counter with synchronous clear, saturation at 9999,
// and a greater-than compare against an external BCD value.
module bcd_counter4
    import game_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rstn,
    input  logic        clr_i,
    input  logic        inc_i,
    input  logic [15:0] cmp_val_i,
    output logic [15:0] count_o,
    output logic        gt_o
);

    logic [15:0] count_q, count_d;
    logic        carry;

    // NOTE: every variable written here gets a value before any branch, so no latch is inferred.
    always_comb begin
        count_d = count_q;
        carry   = 1'b1;
        if (clr_i) begin
            count_d = '0;
        end else if (inc_i && (count_q != BCD_MAX)) begin
            for (int i = 0; i < 4; i++) begin
                if (carry) begin
                    if (count_q[4*i +: 4] == 4'd9) begin
                        count_d[4*i +: 4] = 4'd0;
                    end else begin
                        count_d[4*i +: 4] = count_q[4*i +: 4] + 4'd1;
                        carry             = 1'b0;
                    end
                end
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
    assign gt_o    = bcd_gt(count_q, cmp_val_i);

endmodule

// File: rtl/game_ctrl.sv
// Game sequencer: IDLE/READY/PLAY/DIE/OVER state machine, flap and reset strobes,
// physics/scroll gating and current/best BCD score. All outputs are registered.
module game_ctrl
    import game_ctrl_pkg::*;
#(
    parameter int DIE_FRAMES       = 45,
    parameter int OVER_HOLD_FRAMES = 60,
    parameter int FCNT_W           = 8
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        button_pulse,
    input  logic        new_frame,
    input  logic        collide,
    input  logic        hit_ground,
    input  logic        pipe_passed,
    output logic [2:0]  state,
    output logic        game_reset,
    output logic        flap,
    output logic        physics_en,
    output logic        scroll_en,
    output logic [1:0]  bird_status,
    output logic [15:0] score,
    output logic [15:0] best_score
);

    localparam logic [FCNT_W-1:0] DIE_LAST  = FCNT_W'(DIE_FRAMES - 1);
    localparam logic [FCNT_W-1:0] OVER_HOLD = FCNT_W'(OVER_HOLD_FRAMES);

    state_e            state_q, state_d;
    logic [FCNT_W-1:0] fcnt_q, fcnt_d;
    logic              game_reset_q, game_reset_d;
    logic              flap_q, flap_d;
    logic              physics_en_q, physics_en_d;
    logic              scroll_en_q, scroll_en_d;
    bird_e             bird_q, bird_d;
    logic [15:0]       best_q, best_d;

    logic              score_clr;
    logic              score_inc;
    logic              score_gt;
    logic [15:0]       score_w;

    bcd_counter4 u_score (
        .clk       (clk),
        .rstn      (rstn),
        .clr_i     (score_clr),
        .inc_i     (score_inc),
        .cmp_val_i (best_q),
        .count_o   (score_w),
        .gt_o      (score_gt)
    );

    always_comb begin
        state_d      = state_q;
        fcnt_d       = fcnt_q;
        game_reset_d = 1'b0;
        flap_d       = 1'b0;
        best_d       = best_q;
        score_clr    = 1'b0;
        score_inc    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (button_pulse) begin
                    state_d      = ST_READY;
                    game_reset_d = 1'b1;
                    score_clr    = 1'b1;
                end
            end
            ST_READY: begin
                if (button_pulse) begin
                    state_d = ST_PLAY;
                    flap_d  = 1'b1;
                end
            end
            ST_PLAY: begin
                score_inc = pipe_passed;
                // A collision overrides a same-cycle flap request.
                if (collide) begin
                    state_d = ST_DIE;
                    fcnt_d  = '0;
                end else if (button_pulse) begin
                    flap_d = 1'b1;
                end
            end
            ST_DIE: begin
                if (new_frame) begin
                    fcnt_d = fcnt_q + FCNT_W'(1);
                end
                if (hit_ground || (new_frame && (fcnt_q == DIE_LAST))) begin
                    state_d = ST_OVER;
                    fcnt_d  = '0;
                    if (score_gt) begin
                        best_d = score_w;
                    end
                end
            end
            ST_OVER: begin
                if (new_frame && (fcnt_q < OVER_HOLD)) begin
                    fcnt_d = fcnt_q + FCNT_W'(1);
                end
                if (button_pulse && (fcnt_q >= OVER_HOLD)) begin
                    state_d      = ST_READY;
                    game_reset_d = 1'b1;
                    score_clr    = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Gating outputs follow the state being entered so they line up with it.
        physics_en_d = 1'b0;
        scroll_en_d  = 1'b0;
        bird_d       = BIRD_HOVER;
        case (state_d)
            ST_READY: scroll_en_d = 1'b1;
            ST_PLAY: begin
                physics_en_d = 1'b1;
                scroll_en_d  = 1'b1;
                bird_d       = BIRD_FLY;
            end
            ST_DIE: begin
                physics_en_d = 1'b1;
                bird_d       = BIRD_DEAD;
            end
            ST_OVER:  bird_d = BIRD_DEAD;
            default:  bird_d = BIRD_HOVER;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= ST_IDLE;
            fcnt_q       <= '0;
            game_reset_q <= 1'b0;
            flap_q       <= 1'b0;
            physics_en_q <= 1'b0;
            scroll_en_q  <= 1'b0;
            bird_q       <= BIRD_HOVER;
            best_q       <= '0;
        end else begin
            state_q      <= state_d;
            fcnt_q       <= fcnt_d;
            game_reset_q <= game_reset_d;
            flap_q       <= flap_d;
            physics_en_q <= physics_en_d;
            scroll_en_q  <= scroll_en_d;
            bird_q       <= bird_d;
            best_q       <= best_d;
        end
    end

    assign state       = state_q;
    assign game_reset  = game_reset_q;
    assign flap        = flap_q;
    assign physics_en  = physics_en_q;
    assign scroll_en   = scroll_en_q;
    assign bird_status = bird_q;
    assign score       = score_w;
    assign best_score  = best_q;

endmodule

// File: tb/tb_game_ctrl.sv
// Directed bench for game_ctrl: walks two full games, score carry/saturation,
// DIE/OVER frame timing and asynchronous reset, with hand-computed expectations.
module tb_game_ctrl;

    logic        clk;
    logic        rstn;
    logic        button_pulse;
    logic        new_frame;
    logic        collide;
    logic        hit_ground;
    logic        pipe_passed;
    logic [2:0]  state;
    logic        game_reset;
    logic        flap;
    logic        physics_en;
    logic        scroll_en;
    logic [1:0]  bird_status;
    logic [15:0] score;
    logic [15:0] best_score;

    int passed = 0;
    int total  = 0;

    game_ctrl dut (
        .clk          (clk),
        .rstn         (rstn),
        .button_pulse (button_pulse),
        .new_frame    (new_frame),
        .collide      (collide),
        .hit_ground   (hit_ground),
        .pipe_passed  (pipe_passed),
        .state        (state),
        .game_reset   (game_reset),
        .flap         (flap),
        .physics_en   (physics_en),
        .scroll_en    (scroll_en),
        .bird_status  (bird_status),
        .score        (score),
        .best_score   (best_score)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Advance one clock; outputs are sampled 1 ns after the edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic press();
        button_pulse = 1'b1;
        cyc();
        button_pulse = 1'b0;
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) begin
            new_frame = 1'b1;
            cyc();
            new_frame = 1'b0;
            cyc();
        end
    endtask

    task automatic passes(input int n);
        pipe_passed = 1'b1;
        repeat (n) cyc();
        pipe_passed = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_state"},  16'(state),       16'h0);
        check({tag, "_strobe"}, {14'h0, game_reset, flap}, 16'h0);
        check({tag, "_gate"},   {14'h0, physics_en, scroll_en}, 16'h0);
        check({tag, "_bird"},   16'(bird_status), 16'h0);
        check({tag, "_score"},  score,            16'h0);
        check({tag, "_best"},   best_score,       16'h0);
    endtask

    initial begin
        rstn         = 1'b0;
        button_pulse = 1'b0;
        new_frame    = 1'b0;
        collide      = 1'b0;
        hit_ground   = 1'b0;
        pipe_passed  = 1'b0;
        #23;
        check_reset_outputs("rst");
        rstn = 1'b1;
        repeat (10) cyc();

        // Game 1: IDLE -> READY -> PLAY, score 3, collide+pass, hit ground.
        press();
        check("ready_state", 16'(state), 16'd1);
        check("ready_greset", 16'(game_reset), 16'd1);
        check("ready_gate", {14'h0, physics_en, scroll_en}, 16'b01);
        cyc();
        check("ready_greset_one", 16'(game_reset), 16'd0);

        press();
        check("play_state", 16'(state), 16'd2);
        check("play_flap", 16'(flap), 16'd1);
        check("play_gate", {14'h0, physics_en, scroll_en}, 16'b11);
        check("play_bird", 16'(bird_status), 16'd1);
        cyc();
        check("play_flap_one", 16'(flap), 16'd0);
        press();
        check("play_button_flap", 16'(flap), 16'd1);
        check("play_button_greset", 16'(game_reset), 16'd0);

        passes(2);
        collide = 1'b1;
        pipe_passed = 1'b1;
        cyc();
        collide = 1'b0;
        pipe_passed = 1'b0;
        check("g1_die_state", 16'(state), 16'd3);
        check("g1_pass_with_collide", score, 16'h0003);

        passes(1);
        check("die_pass_ignored", score, 16'h0003);
        press();
        check("die_button_ignored", 16'(state), 16'd3);
        hit_ground = 1'b1;
        cyc();
        hit_ground = 1'b0;
        check("g1_over_state", 16'(state), 16'd4);
        check("g1_over_gate", {14'h0, physics_en, scroll_en}, 16'b00);
        check("g1_over_bird", 16'(bird_status), 16'd2);
        check("g1_best", best_score, 16'h0003);

        // Game 2: score 7, button+collide, DIE timeout after 45 frames.
        frames(60);
        press();
        check("g2_ready_state", 16'(state), 16'd1);
        check("g2_score_clear", score, 16'h0000);
        check("g2_greset", 16'(game_reset), 16'd1);
        cyc();
        press();
        passes(7);
        check("g2_score", score, 16'h0007);
        collide = 1'b1;
        button_pulse = 1'b1;
        cyc();
        collide = 1'b0;
        button_pulse = 1'b0;
        check("g2_die_state", 16'(state), 16'd3);
        check("g2_die_no_flap", 16'(flap), 16'd0);
        check("g2_die_gate", {14'h0, physics_en, scroll_en}, 16'b10);
        check("g2_die_bird", 16'(bird_status), 16'd2);
        cyc();
        check("g2_die_no_flap_late", 16'(flap), 16'd0);

        frames(44);
        check("g2_die_after44", 16'(state), 16'd3);
        new_frame = 1'b1;
        cyc();
        new_frame = 1'b0;
        check("g2_over_after45", 16'(state), 16'd4);
        check("g2_best", best_score, 16'h0007);

        frames(10);
        press();
        check("over_early_button", 16'(state), 16'd4);
        check("over_early_greset", 16'(game_reset), 16'd0);
        frames(49);
        press();
        check("over_59_button", 16'(state), 16'd4);
        frames(1);
        press();
        check("over_late_button", 16'(state), 16'd1);
        check("over_late_score", score, 16'h0000);
        check("over_late_best", best_score, 16'h0007);
        check("over_late_greset", 16'(game_reset), 16'd1);
        cyc();
        check("over_late_greset_one", 16'(game_reset), 16'd0);

        // Game 3: BCD carry and saturation.
        press();
        passes(12);
        check("score_12", score, 16'h0012);
        passes(987);
        check("score_999", score, 16'h0999);
        passes(1);
        check("score_1000", score, 16'h1000);
        passes(8999);
        check("score_9999", score, 16'h9999);
        passes(1);
        check("score_sat", score, 16'h9999);
        collide = 1'b1;
        cyc();
        collide = 1'b0;
        hit_ground = 1'b1;
        cyc();
        hit_ground = 1'b0;
        check("g3_best", best_score, 16'h9999);

        // Game 4: asynchronous reset in PLAY with score 42.
        frames(60);
        press();
        cyc();
        press();
        passes(42);
        check("g4_score", score, 16'h0042);
        #2;
        rstn = 1'b0;
        #2;
        check_reset_outputs("async_rst");
        #10;
        rstn = 1'b1;
        cyc();
        check("post_rst_state", 16'(state), 16'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
